aidan_mcnay_edge_debounce: RTL and testbench
============================================

// Module: aidan_mcnay_edge_debounce
//
// PURPOSE
//  - N-channel input conditioner: per-channel synchroniser, debounce filter and edge detector.
//  - Emits one-cycle pulses on rising, falling or both edges, selected by a runtime mode.
//  - Sits between raw asynchronous inputs (buttons, external strobes) and the control FSMs.
//  - Adds a debounced level output and optional sticky event flags.
//
// PARAMETERS
//  - N_CHAN          default 1  : number of independent channels (>=1)
//  - SYNC_STAGES     default 2  : synchroniser flops per channel (>=2)
//  - DEBOUNCE_CYCLES default 1  : consecutive mismatching samples needed to accept a new level (>=1; 1 = no filtering)
//
// PORTS
//  - clk         input   1       : single clock; all state updates on posedge
//  - rst_n       input   1       : asynchronous, active-low reset
//  - in_signal   input   N_CHAN  : raw asynchronous inputs
//  - mode        input   2       : 00 none, 01 rise, 10 fall, 11 both; shared by all channels, synchronous to clk
//  - level       output  N_CHAN  : debounced, synchronised level
//  - out_signal  output  N_CHAN  : registered one-cycle edge pulse per channel
//  - pending     output  N_CHAN  : [EDGE_DEBOUNCE_STICKY_EN only] sticky event flag
//  - ack         input   N_CHAN  : [EDGE_DEBOUNCE_STICKY_EN only] clears pending per channel
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): clears all sync flops, debounce counters, level, out_signal and pending to 0.
//  - Sync: in_signal passes through an SYNC_STAGES-deep shift chain; s = last stage.
//  - Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
//    - s==level: counter <= 0.
//    - s!=level and counter==DEBOUNCE_CYCLES-1: level <= s, counter <= 0.
//    - Otherwise: counter increments.
//    - A glitch shorter than DEBOUNCE_CYCLES samples never changes level.
//  - Edge pulse: registered on the same edge that level flips.
//    - rise = 0->1, fall = 1->0.
//    - out_signal <= (rise & mode[0]) | (fall & mode[1]); otherwise 0.
//    - Pulse width is exactly 1 cycle.
//  - Latency: input change stable before edge E0 -> level and out_signal asserted after edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1).
//  - mode is sampled on the edge where level flips; a mode change never creates or cancels pulses for past flips.
//  - Input held high through reset release: one rise event after the nominal latency (level resets to 0).
//  - Reset asserted mid-debounce: the count is discarded; no pulse.
//  - Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
//
// CONFIGURATION
//  - Macro EDGE_DEBOUNCE_STICKY_EN:
//    - Defined: ports pending/ack exist.
//      - pending[i] <= 1 on any cycle out_signal[i] is being set.
//      - ack[i]=1 clears pending[i] on the next edge.
//      - Simultaneous new pulse and ack: set wins, pending stays 1.
//    - Undefined: no pending/ack ports and no flag logic; all other behaviour is identical.
//
// STRUCTURE
//  - Shared header src/edge_debounce_defs.v (`ifndef-guarded):
//    - Mode constants EDGE_MODE_NONE/RISE/FALL/BOTH (2'b00..2'b11).
//    - Counter-width helper.
//  - Sub-module aidan_mcnay_debounce_chan: one channel covering sync chain, counter, level, pulse and sticky flag.
//  - Top module generates N_CHAN instances of it and shares mode.
//
// TESTING
//  - N=1, SYNC=2, DB=1, mode=01: in 0->1 -> out_signal high for exactly one cycle, 3 edges later; level=1.
//  - DB=4, mode=11: 3-cycle high glitch -> no pulse, level stays 0.
//    - 6-cycle high -> one pulse after 5 edges; then release -> one fall pulse.
//  - mode=10 rise then fall -> pulse only on fall; mode=00 -> never pulses but level still tracks.
//  - N=4: channels 0 and 3 rise on the same cycle -> out_signal=4'b1001 for one cycle; others 0.
//  - Reset at counter=2 of DB=4 -> all outputs 0 immediately (async).
//    - Input held high through release -> single rise pulse SYNC+DB-1 edges after release.
//  - STICKY_EN: pulse -> pending=1 held until ack; ack coincident with new pulse -> pending stays 1.

Source files
------------

// File: rtl/aidan_mcnay_edge_debounce_pkg.sv
// +----------------------------------------------------------------------------+
// | aidan_mcnay_edge_debounce_pkg                                              |
// | Edge-mode encodings and debounce counter width helper.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package aidan_mcnay_edge_debounce_pkg;

  localparam logic [1:0] EDGE_MODE_NONE = 2'b00;
  localparam logic [1:0] EDGE_MODE_RISE = 2'b01;
  localparam logic [1:0] EDGE_MODE_FALL = 2'b10;
  localparam logic [1:0] EDGE_MODE_BOTH = 2'b11;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aidan_mcnay_debounce_chan.sv
// +----------------------------------------------------------------------------+
// | aidan_mcnay_debounce_chan                                                  |
// | One channel: synchroniser, debounce filter, level and edge pulse.          |
// | Optional sticky flag when EDGE_DEBOUNCE_STICKY_EN is defined.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module aidan_mcnay_debounce_chan
  import aidan_mcnay_edge_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_signal,
  input  logic [1:0] mode,
  output logic       level,
  output logic       out_signal
`ifdef EDGE_DEBOUNCE_STICKY_EN
  ,
  output logic       pending,
  input  logic       ack
`endif
);

  localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_level;
  logic                   r_out;

  logic w_s;
  logic w_mismatch;
  logic w_flip;
  logic w_rise_en;
  logic w_fall_en;
  logic w_pulse;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_s ^ r_level;
  assign w_flip     = w_mismatch && (r_cnt == c_cnt_last);
  assign w_rise_en  = (mode == EDGE_MODE_RISE) || (mode == EDGE_MODE_BOTH);
  assign w_fall_en  = (mode == EDGE_MODE_FALL) || (mode == EDGE_MODE_BOTH);
  // w_s is the new level on a flip, so it selects rise versus fall.
  assign w_pulse    = w_flip && (w_s ? w_rise_en : w_fall_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_signal};
      r_out  <= w_pulse;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign level      = r_level;
  assign out_signal = r_out;

`ifdef EDGE_DEBOUNCE_STICKY_EN
  logic r_pending;

  // A new pulse outranks a coincident ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_pulse | (r_pending & ~ack);
    end
  end

  assign pending = r_pending;
`endif

endmodule

`default_nettype wire

// File: rtl/aidan_mcnay_edge_debounce.sv
// +----------------------------------------------------------------------------+
// | aidan_mcnay_edge_debounce                                                  |
// | N-channel synchronise / debounce / edge-detect with shared mode.           |
// | Sticky pending/ack ports exist when EDGE_DEBOUNCE_STICKY_EN is defined.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module aidan_mcnay_edge_debounce
  import aidan_mcnay_edge_debounce_pkg::*;
#(
  parameter int N_CHAN          = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CHAN-1:0] in_signal,
  input  logic [1:0]        mode,
  output logic [N_CHAN-1:0] level,
  output logic [N_CHAN-1:0] out_signal
`ifdef EDGE_DEBOUNCE_STICKY_EN
  ,
  output logic [N_CHAN-1:0] pending,
  input  logic [N_CHAN-1:0] ack
`endif
);

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    aidan_mcnay_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_signal  (in_signal[i]),
      .mode       (mode),
      .level      (level[i]),
      .out_signal (out_signal[i])
`ifdef EDGE_DEBOUNCE_STICKY_EN
      ,
      .pending    (pending[i]),
      .ack        (ack[i])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_aidan_mcnay_edge_debounce.sv
// +----------------------------------------------------------------------------+
// | tb_aidan_mcnay_edge_debounce                                               |
// | Directed scenarios plus randomized run against a history-window model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aidan_mcnay_edge_debounce;

  localparam int c_b_sync = 2;
  localparam int c_b_db   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_in;
  logic [1:0] a_mode;
  logic       a_level;
  logic       a_out;
  logic [3:0] b_in;
  logic [1:0] b_mode;
  logic [3:0] b_level;
  logic [3:0] b_out;
`ifdef EDGE_DEBOUNCE_STICKY_EN
  logic       a_pending;
  logic       a_ack;
  logic [3:0] b_pending;
  logic [3:0] b_ack;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aidan_mcnay_edge_debounce #(
    .N_CHAN(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_signal  (a_in),
    .mode       (a_mode),
    .level      (a_level),
    .out_signal (a_out)
`ifdef EDGE_DEBOUNCE_STICKY_EN
    ,
    .pending    (a_pending),
    .ack        (a_ack)
`endif
  );

  aidan_mcnay_edge_debounce #(
    .N_CHAN(4), .SYNC_STAGES(c_b_sync), .DEBOUNCE_CYCLES(c_b_db)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_signal  (b_in),
    .mode       (b_mode),
    .level      (b_level),
    .out_signal (b_out)
`ifdef EDGE_DEBOUNCE_STICKY_EN
    ,
    .pending    (b_pending),
    .ack        (b_ack)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    a_in   = 1'b0;
    a_mode = 2'b00;
    b_in   = 4'b0;
    b_mode = 2'b00;
`ifdef EDGE_DEBOUNCE_STICKY_EN
    a_ack = 1'b0;
    b_ack = 4'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL reset_a_level got %b want 0", a_level); end
    checks++; if (a_out !== 1'b0) begin errors++; $display("FAIL reset_a_out got %b want 0", a_out); end
    checks++; if (b_level !== 4'b0) begin errors++; $display("FAIL reset_b_level got %b want 0000", b_level); end
    checks++; if (b_out !== 4'b0) begin errors++; $display("FAIL reset_b_out got %b want 0000", b_out); end
`ifdef EDGE_DEBOUNCE_STICKY_EN
    checks++; if (a_pending !== 1'b0) begin errors++; $display("FAIL reset_a_pending got %b want 0", a_pending); end
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_rise();
    a_mode = 2'b01;
    a_in   = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (a_out !== (e == 2)) begin errors++; $display("FAIL basic_rise_out edge %0d got %b want %b", e, a_out, (e == 2)); end
      checks++;
      if (a_level !== (e >= 2)) begin errors++; $display("FAIL basic_rise_level edge %0d got %b want %b", e, a_level, (e >= 2)); end
    end
    a_in = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (a_out !== 1'b0) begin errors++; $display("FAIL basic_nofall_out edge %0d got %b want 0", e, a_out); end
    end
    checks++; if (a_level !== 1'b0) begin errors++; $display("FAIL basic_fall_level got %b want 0", a_level); end
  endtask

`ifdef EDGE_DEBOUNCE_STICKY_EN
  task automatic test_sticky();
    a_mode = 2'b11;
    a_ack  = 1'b0;
    a_in   = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (a_pending !== (e >= 2)) begin errors++; $display("FAIL sticky_hold edge %0d got %b want %b", e, a_pending, (e >= 2)); end
    end
    a_in = 1'b0;
    tick();
    tick();
    a_ack = 1'b1;
    tick();
    checks++; if (a_out !== 1'b1) begin errors++; $display("FAIL sticky_fall_pulse got %b want 1", a_out); end
    checks++; if (a_pending !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b want 1", a_pending); end
    tick();
    a_ack = 1'b0;
    checks++; if (a_pending !== 1'b0) begin errors++; $display("FAIL sticky_ack_clear got %b want 0", a_pending); end
  endtask
`endif

  task automatic test_glitch();
    int pulses;
    logic seen_level;
    b_mode = 2'b11;
    pulses = 0;
    seen_level = 1'b0;
    b_in = 4'b0001;
    for (int e = 0; e < 12; e++) begin
      if (e == 3) b_in = 4'b0000;
      tick();
      if (b_out !== 4'b0) pulses++;
      if (b_level !== 4'b0) seen_level = 1'b1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    checks++; if (seen_level !== 1'b0) begin errors++; $display("FAIL glitch_level got %b want 0", seen_level); end
    b_in = 4'b0001;
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (b_out !== ((e == 5) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL long_rise_out edge %0d got %b", e, b_out); end
    end
    checks++; if (b_level !== 4'b0001) begin errors++; $display("FAIL long_rise_level got %b want 0001", b_level); end
    b_in = 4'b0000;
    for (int e = 0; e < 9; e++) begin
      tick();
      checks++;
      if (b_out !== ((e == 5) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL release_fall_out edge %0d got %b", e, b_out); end
    end
    checks++; if (b_level !== 4'b0000) begin errors++; $display("FAIL release_level got %b want 0000", b_level); end
  endtask

  task automatic test_mode_fall_none();
    b_mode = 2'b10;
    b_in   = 4'b0010;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (b_out !== 4'b0) begin errors++; $display("FAIL fallmode_rise_out edge %0d got %b want 0000", e, b_out); end
    end
    checks++; if (b_level !== 4'b0010) begin errors++; $display("FAIL fallmode_level_hi got %b want 0010", b_level); end
    b_in = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (b_out !== ((e == 5) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL fallmode_fall_out edge %0d got %b", e, b_out); end
    end
    b_mode = 2'b00;
    b_in   = 4'b0100;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (b_out !== 4'b0) begin errors++; $display("FAIL nonemode_out edge %0d got %b want 0000", e, b_out); end
    end
    checks++; if (b_level !== 4'b0100) begin errors++; $display("FAIL nonemode_level got %b want 0100", b_level); end
    b_in = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (b_out !== 4'b0) begin errors++; $display("FAIL nonemode_fall_out edge %0d got %b want 0000", e, b_out); end
    end
    checks++; if (b_level !== 4'b0000) begin errors++; $display("FAIL nonemode_level_lo got %b want 0000", b_level); end
  endtask

  task automatic test_multi_chan();
    b_mode = 2'b01;
    b_in   = 4'b1001;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (b_out !== ((e == 5) ? 4'b1001 : 4'b0000)) begin errors++; $display("FAIL multi_out edge %0d got %b", e, b_out); end
    end
    b_mode = 2'b00;
    b_in   = 4'b0000;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_reset_mid();
    b_mode = 2'b01;
    b_in   = 4'b1000;
    for (int e = 0; e < 8; e++) tick();
    b_in = 4'b1001;
    for (int e = 0; e < 4; e++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b_level !== 4'b0) begin errors++; $display("FAIL midreset_level got %b want 0000", b_level); end
    checks++; if (b_out !== 4'b0) begin errors++; $display("FAIL midreset_out got %b want 0000", b_out); end
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      checks++;
      if (b_out !== ((e == 5) ? 4'b1001 : 4'b0000)) begin errors++; $display("FAIL post_release_out edge %0d got %b", e, b_out); end
    end
    b_mode = 2'b00;
    b_in   = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] hist[$];
    logic [3:0] m_level;
    logic [3:0] m_out;
    bit         all_new;
    logic       v;
    int         idx;
    #2 rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_level = 4'b0;
    hist.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(4, 0) == 0) b_in[c] = ~b_in[c];
      if ($urandom_range(7, 0) == 0) b_mode = 2'($urandom_range(3, 0));
      tick();
      // Level flips when the last DEBOUNCE_CYCLES synchronised samples all oppose it.
      hist.push_front(b_in);
      if (hist.size() > c_b_sync + c_b_db) void'(hist.pop_back());
      m_out = 4'b0;
      for (int c = 0; c < 4; c++) begin
        all_new = 1'b1;
        for (int j = 0; j < c_b_db; j++) begin
          idx = c_b_sync + j;
          v   = (idx < hist.size()) ? hist[idx][c] : 1'b0;
          if (v == m_level[c]) all_new = 1'b0;
        end
        if (all_new) begin
          m_level[c] = ~m_level[c];
          m_out[c]   = m_level[c] ? b_mode[0] : b_mode[1];
        end
      end
      checks++;
      if (b_out !== m_out) begin errors++; $display("FAIL rand_out cyc %0d got %b want %b", cyc, b_out, m_out); end
      checks++;
      if (b_level !== m_level) begin errors++; $display("FAIL rand_level cyc %0d got %b want %b", cyc, b_level, m_level); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rise();
`ifdef EDGE_DEBOUNCE_STICKY_EN
    test_sticky();
`endif
    test_glitch();
    test_mode_fall_none();
    test_multi_chan();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
